// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with selectable first-word-fall-through read, exact fill count,
// programmable almost-full/almost-empty flags, sticky error flags and synchronous flush.
module sync_fifo_fwft #(
    parameter int unsigned DSIZE         = 32,
    parameter int unsigned ASIZE         = 8,
    parameter int unsigned FWFT          = 1,
    parameter int unsigned AFULL_THRESH  = (1 << ASIZE) - 2,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned    DEPTH      = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_CNT  = (ASIZE + 1)'(DEPTH);
    localparam logic [ASIZE:0] AFULL_CNT  = (ASIZE + 1)'(AFULL_THRESH);
    localparam logic [ASIZE:0] AEMPTY_CNT = (ASIZE + 1)'(AEMPTY_THRESH);

    if (ASIZE < 1 || FWFT > 1 || AFULL_THRESH > DEPTH || AEMPTY_THRESH >= AFULL_THRESH) begin : g_param_check
        $error("sync_fifo_fwft: illegal parameter combination");
    end

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   rptr;
    logic             wr_ok;
    logic             rd_ok;
    logic             mem_rd;

    always_comb begin
        wfull         = (count == DEPTH_CNT);
        walmost_full  = (count >= AFULL_CNT);
        ralmost_empty = (count <= AEMPTY_CNT);
        wr_ok         = winc & ~wfull & ~flush;
        rd_ok         = rinc & ~rempty & ~flush;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr[ASIZE-1:0]] <= wdata;
        end
    end

    // Error flags are judged on pre-edge full/empty, independent of the other side's request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (mem_rd) begin
                rptr <= rptr + 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                count <= count + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count <= count - 1'b1;
            end
            if (winc && wfull) begin
                overflow <= 1'b1;
            end
            if (rinc && rempty) begin
                underflow <= 1'b1;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        logic out_valid;

        // The stage refills only from words already in memory before this edge, so a
        // word being written now is never fetched from the address under write.
        always_comb begin
            mem_rd = ~flush & (wptr != rptr) & (~out_valid | rd_ok);
            rempty = ~out_valid;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid <= 1'b0;
                rdata     <= '0;
            end else if (flush) begin
                out_valid <= 1'b0;
            end else if (mem_rd) begin
                rdata     <= mem[rptr[ASIZE-1:0]];
                out_valid <= 1'b1;
            end else if (rd_ok) begin
                out_valid <= 1'b0;
            end
        end
    end else begin : g_std
        always_comb begin
            mem_rd = rd_ok;
            rempty = (count == '0);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata <= '0;
            end else if (rd_ok) begin
                rdata <= mem[rptr[ASIZE-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Scoreboard bench driving a standard-read and a fall-through instance with shared stimulus.
module tb_sync_fifo_fwft;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AF    = 3;
    localparam int unsigned AE    = 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          flush = 1'b0;
    logic          winc  = 1'b0;
    logic          rinc  = 1'b0;
    logic [DW-1:0] wdata = '0;

    logic [DW-1:0] s_rdata, f_rdata;
    logic [AW:0]   s_count, f_count;
    logic s_wfull, s_afull, s_rempty, s_aempty, s_ovf, s_unf;
    logic f_wfull, f_afull, f_rempty, f_aempty, f_ovf, f_unf;

    int total = 0;
    int bad   = 0;

    sync_fifo_fwft #(.DSIZE(DW), .ASIZE(AW), .FWFT(0), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wdata(wdata), .winc(winc),
        .wfull(s_wfull), .walmost_full(s_afull), .rinc(rinc), .rdata(s_rdata),
        .rempty(s_rempty), .ralmost_empty(s_aempty), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_fwft #(.DSIZE(DW), .ASIZE(AW), .FWFT(1), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wdata(wdata), .winc(winc),
        .wfull(f_wfull), .walmost_full(f_afull), .rinc(rinc), .rdata(f_rdata),
        .rempty(f_rempty), .ralmost_empty(f_aempty), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    always #5 clk = ~clk;

    // Reference model: queue contents with the edge each word was written on.
    typedef struct {
        logic [DW-1:0] d;
        int unsigned   e;
    } ent_t;

    ent_t          sq[$];
    ent_t          fq[$];
    logic [DW-1:0] s_exp[$];
    logic [DW-1:0] f_exp[$];
    logic [DW-1:0] s_last = '0;
    logic [DW-1:0] f_last = '0;
    bit s_ov = 0, s_un = 0, f_ov = 0, f_un = 0;
    int unsigned edge_no = 0;

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Fall-through head is visible only once it was written on an earlier edge than the last one.
    function automatic bit f_shown();
        return (fq.size() > 0) && (fq[0].e < edge_no);
    endfunction

    task automatic check_flags();
        chk("s_count", 32'(s_count), sq.size());
        chk("s_rempty", 32'(s_rempty), 32'(sq.size() == 0));
        chk("s_wfull", 32'(s_wfull), 32'(sq.size() == DEPTH));
        chk("s_almost_full", 32'(s_afull), 32'(sq.size() >= AF));
        chk("s_almost_empty", 32'(s_aempty), 32'(sq.size() <= AE));
        chk("s_overflow", 32'(s_ovf), 32'(s_ov));
        chk("s_underflow", 32'(s_unf), 32'(s_un));
        chk("s_rdata_hold", 32'(s_rdata), 32'(s_last));
        chk("f_count", 32'(f_count), fq.size());
        chk("f_rempty", 32'(f_rempty), 32'(!f_shown()));
        chk("f_wfull", 32'(f_wfull), 32'(fq.size() == DEPTH));
        chk("f_almost_full", 32'(f_afull), 32'(fq.size() >= AF));
        chk("f_almost_empty", 32'(f_aempty), 32'(fq.size() <= AE));
        chk("f_overflow", 32'(f_ovf), 32'(f_ov));
        chk("f_underflow", 32'(f_unf), 32'(f_un));
        chk("f_rdata_hold", 32'(f_rdata), 32'(f_last));
    endtask

    // One clock cycle: entered and left 1 time unit after a rising edge.
    task automatic cycle(input bit w, input bit r, input bit fl, input logic [DW-1:0] d);
        bit   s_full, s_emp, f_full, f_emp, s_wa, s_ra, f_wa, f_ra;
        ent_t e;
        winc = w; rinc = r; flush = fl; wdata = d;
        s_full = (sq.size() == DEPTH);
        s_emp  = (sq.size() == 0);
        f_full = (fq.size() == DEPTH);
        f_emp  = !f_shown();
        s_wa = w && !fl && !s_full;
        s_ra = r && !fl && !s_emp;
        f_wa = w && !fl && !f_full;
        f_ra = r && !fl && !f_emp;
        if (s_ra) s_exp.push_back(sq[0].d);
        if (f_ra) f_exp.push_back(fq[0].d);
        e.d = d;
        e.e = edge_no + 1;
        @(posedge clk);
        #1;
        if (fl) begin
            sq.delete(); fq.delete();
            s_ov = 0; s_un = 0; f_ov = 0; f_un = 0;
        end else begin
            if (w && s_full) s_ov = 1;
            if (r && s_emp)  s_un = 1;
            if (w && f_full) f_ov = 1;
            if (r && f_emp)  f_un = 1;
            if (s_ra) begin s_last = sq[0].d; void'(sq.pop_front()); end
            if (s_wa) sq.push_back(e);
            if (f_ra) void'(fq.pop_front());
            if (f_wa) fq.push_back(e);
        end
        if (f_shown()) f_last = fq[0].d;
        winc = 0; rinc = 0; flush = 0;
        check_flags();
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && (sq.size() > 0 || fq.size() > 0); i++) cycle(0, 1, 0, '0);
        cycle(0, 0, 1, '0);
    endtask

    // Monitor: compares popped data whenever a DUT accepts a read.
    initial begin : monitor
        bit            s_pend;
        logic [DW-1:0] exp;
        s_pend = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                s_pend = 0;
            end else begin
                if (s_pend) begin
                    if (s_exp.size() == 0) begin
                        total++; bad++;
                        $display("FAIL s_pop_data: got %0h expected no read", s_rdata);
                    end else begin
                        exp = s_exp.pop_front();
                        chk("s_pop_data", 32'(s_rdata), 32'(exp));
                    end
                end
                s_pend = rinc && !flush && !s_rempty;
                if (rinc && !flush && !f_rempty) begin
                    if (f_exp.size() == 0) begin
                        total++; bad++;
                        $display("FAIL f_pop_data: got %0h expected no read", f_rdata);
                    end else begin
                        exp = f_exp.pop_front();
                        chk("f_pop_data", 32'(f_rdata), 32'(exp));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int unsigned pw_tab[6] = '{80, 50, 20, 90, 50, 10};
        int unsigned pr_tab[6] = '{20, 50, 80, 40, 50, 90};

        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_flags();
        rst_n = 1'b1;

        // Fill to full, overflow, drain, underflow
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, DW'(8'hA0 + i));
        chk("t1_s_count_full", 32'(s_count), 4);
        chk("t1_s_wfull", 32'(s_wfull), 1);
        cycle(1, 0, 0, 8'hA4);
        chk("t1_s_overflow", 32'(s_ovf), 1);
        chk("t1_f_count_hold", 32'(f_count), 4);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, '0);
        cycle(0, 1, 0, '0);
        chk("t1_s_underflow", 32'(s_unf), 1);
        chk("t1_s_last_word", 32'(s_rdata), 32'h0A3);
        cycle(0, 0, 1, '0);

        // Fall-through latency on an empty FIFO
        cycle(1, 0, 0, 8'h55);
        chk("t2_f_rempty_edge_n", 32'(f_rempty), 1);
        chk("t2_f_count_edge_n", 32'(f_count), 1);
        cycle(0, 0, 0, '0);
        chk("t2_f_rempty_edge_n1", 32'(f_rempty), 0);
        chk("t2_f_rdata_edge_n1", 32'(f_rdata), 32'h055);
        cycle(0, 1, 0, '0);
        chk("t2_f_rempty_pop", 32'(f_rempty), 1);
        chk("t2_f_count_pop", 32'(f_count), 0);

        // Simultaneous requests on a full FIFO, then at count 2
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, DW'(8'hB0 + i));
        cycle(1, 1, 0, 8'hC0);
        chk("t3_f_count_3", 32'(f_count), 3);
        chk("t3_f_overflow", 32'(f_ovf), 1);
        cycle(0, 1, 0, '0);
        cycle(1, 1, 0, 8'hC1);
        cycle(1, 1, 0, 8'hC2);
        chk("t3_f_count_2", 32'(f_count), 2);
        chk("t3_s_count_2", 32'(s_count), 2);
        drain();

        // Pointer wrap with back-to-back write/read pairs
        cycle(1, 0, 0, 8'd0);
        cycle(0, 0, 0, '0);
        for (int i = 1; i < 20; i++) cycle(1, 1, 0, DW'(i));
        drain();

        // Flush with a write in the same cycle, sticky flags set beforehand
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, DW'(8'hD0 + i));
        cycle(0, 1, 0, '0);
        cycle(1, 0, 1, 8'hEE);
        chk("t6_s_count_flush", 32'(s_count), 0);
        chk("t6_f_count_flush", 32'(f_count), 0);
        chk("t6_f_overflow_flush", 32'(f_ovf), 0);
        cycle(0, 1, 1, '0);
        chk("t6_s_underflow_flush", 32'(s_unf), 0);

        // Asynchronous reset between edges with data held
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, DW'(8'hE0 + i));
        cycle(0, 0, 0, '0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_s_count", 32'(s_count), 0);
        chk("rst_f_count", 32'(f_count), 0);
        chk("rst_s_rempty", 32'(s_rempty), 1);
        chk("rst_f_rempty", 32'(f_rempty), 1);
        chk("rst_s_rdata", 32'(s_rdata), 0);
        chk("rst_f_rdata", 32'(f_rdata), 0);
        chk("rst_f_aempty", 32'(f_aempty), 1);
        sq.delete(); fq.delete(); s_exp.delete(); f_exp.delete();
        s_ov = 0; s_un = 0; f_ov = 0; f_un = 0;
        s_last = '0; f_last = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_flags();

        // Randomised traffic in phases biased towards full or empty
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 100; k++) begin
                cycle($urandom_range(99) < pw_tab[b], $urandom_range(99) < pr_tab[b],
                      $urandom_range(63) == 0, DW'($urandom));
            end
        end
        drain();
        cycle(0, 0, 0, '0);
        cycle(0, 0, 0, '0);
        chk("s_scoreboard_leftover", s_exp.size(), 0);
        chk("f_scoreboard_leftover", f_exp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
